// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state encoding and the default datapath width live here.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// then subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             nbit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_nxt,
    output logic             qbit
);

    logic [WIDTH:0] t;

    assign t = {r, nbit};

    // The partial remainder is always below d, so the result fits in WIDTH bits
    always_comb begin
        qbit  = (t >= {1'b0, d});
        r_nxt = qbit ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative 2W/W unsigned divider, one quotient bit per clock,
// with valid/ready handshakes on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_nxt;
    logic             qbit;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             accept;
    logic             fire;
    logic             last_iter;
    logic             dz_in;
    logic             ov_in;

    assign hi        = dividend[2*WIDTH-1:WIDTH];
    assign lo        = dividend[WIDTH-1:0];
    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign dz_in     = (divisor == '0);
    assign ov_in     = (hi >= divisor);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r    (r),
        .nbit (l[WIDTH-1]),
        .d    (dsr),
        .r_nxt(r_nxt),
        .qbit (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (dz_in || ov_in) state_nxt = DONE;
                    else                state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                if (fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out_valid rises one edge after entering DONE and drops on the taking edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            r           <= '0;
            l           <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            out_valid <= (state == DONE) && !fire;
            if (accept) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                dsr         <= divisor;
                cnt         <= '0;
                if (dz_in) begin
                    quotient    <= '1;
                    remainder   <= lo;
                    div_by_zero <= 1'b1;
                end else if (ov_in) begin
                    quotient  <= '1;
                    remainder <= '0;
                    overflow  <= 1'b1;
                end else begin
                    r <= hi;
                    l <= lo;
                end
            end
            if (state == CALC) begin
                r   <= r_nxt;
                l   <= {l[WIDTH-2:0], qbit};
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    quotient  <= {l[WIDTH-2:0], qbit};
                    remainder <= r_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and round-trip checks for the sequential divider.
// Expected values come from hand-computed vectors and a*b+r construction.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] b,
                         output int lat);
        int k;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input logic edz,
                       input logic eov, input int elat);
        int lat;
        start(a, b, lat);
        if (elat > 0) check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_ov"}, 32'(overflow), 32'(eov));
        take(tag);
    endtask

    initial begin
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rr;
        logic [31:0] rd;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("norm", 32'd100000, 16'd300, 16'd333, 16'd100, 1'b0, 1'b0, 17);
        run("maxex", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b0, 17);
        run("zero", 32'd0, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 17);
        run("dz", 32'h1234ABCD, 16'h0, 16'hFFFF, 16'hABCD, 1'b1, 1'b0, 1);
        run("ovf", 32'h00010000, 16'd1, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1);
        run("hi_lt", 32'h0000FFFF, 16'd1, 16'hFFFF, 16'h0, 1'b0, 1'b0, 17);
        run("flagclr", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17);

        // Backpressure: result held, new operands ignored
        start(32'd100000, 16'd300, lat);
        check("bp_lat", 32'(lat), 32'd17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 32'd5;
            divisor  = 16'd1;
            check("bp_q", 32'(quotient), 32'd333);
            check("bp_r", 32'(remainder), 32'd100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_rel_idle", 32'(in_ready), 32'd1);
        check("bp_rel_ov", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 check("bp_gap_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration sequence
        @(negedge clk);
        dividend = 32'd123456;
        divisor  = 16'd789;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mr_ov", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_q", 32'(quotient), 32'd0);
        check("mr_r", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mr_post_ready", 32'(in_ready), 32'd1);
        run("mr_next", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17);

        // Round trip: dividend built as a*b+r with r<b
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(1, 65535));
            rr = 16'($urandom_range(0, int'(rb) - 1));
            rd = 32'(ra) * 32'(rb) + 32'(rr);
            run("rt", rd, rb, ra, rr, 1'b0, 1'b0, 17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
